lcd_bus_responder: RTL and testbench

- Device end of the HD44780-style 8-bit LCD bus (LCD_RS/LCD_RW/LCD_E/LCD_DB) that the chess-timer display driver writes to.
- Decodes every bus transfer, emulates HD44780 busy timing and keeps a 2x16 DDRAM shadow.
- Exposes the shadow through a read port, so a later mirror or debug block can show exactly what the LCD shows.
- Also serves as a synthesizable self-check of the driver's protocol.

---
 rtl/lcd_pkg.sv | 58 +++++
 rtl/lcd_in_sync.sv | 36 +++
 rtl/lcd_bus_responder.sv | 175 +++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address helpers for the LCD bus responder.
package lcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StClear
  } lcd_state_e;

  // Instruction opcode masks; the highest set bit selects the instruction.
  localparam logic [7:0] OpSetDdram  = 8'h80;
  localparam logic [7:0] OpSetCgram  = 8'h40;
  localparam logic [7:0] OpFuncSet   = 8'h20;
  localparam logic [7:0] OpShift     = 8'h10;
  localparam logic [7:0] OpDispCtrl  = 8'h08;
  localparam logic [7:0] OpEntryMode = 8'h04;
  localparam logic [7:0] OpHome      = 8'h02;
  localparam logic [7:0] OpClear     = 8'h01;

  localparam logic [6:0] Line1Base = 7'h00;
  localparam logic [6:0] Line2Base = 7'h40;
  localparam logic [6:0] Line1End  = 7'h27;
  localparam logic [6:0] Line2End  = 7'h67;

  localparam logic [7:0] Blank = 8'h20;

  function automatic logic has_op(input logic [7:0] db, input logic [7:0] op);
    return (db & op) != 8'h00;
  endfunction

  // Legal DDRAM addresses in 2-line mode.
  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= Line1End) || ((a >= Line2Base) && (a <= Line2End));
  endfunction

  // Address counter step with the line-to-line wrap of a 2-line display.
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == Line1End) return Line2Base;
      else if (a == Line2End) return Line1Base;
      else return a + 7'd1;
    end else begin
      if (a == Line1Base) return Line2End;
      else if (a == Line2Base) return Line1End;
      else return a - 7'd1;
    end
  endfunction

  // True when the address maps to one of the 16 visible columns of either line.
  function automatic logic shadow_hit(input logic [6:0] a);
    return ((a & 7'h70) == Line1Base) || ((a & 7'h70) == Line2Base);
  endfunction

  function automatic logic [4:0] shadow_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Synchronizes the asynchronous LCD bus and flags the falling edge of E.
module lcd_in_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_db,
  output logic       fall,
  output logic       rs,
  output logic       rw,
  output logic [7:0] db
);

  // Bit layout: {rs, rw, e, db[7:0]}
  logic [10:0] sync1_q, sync2_q, dly_q;

  // Two synchronizer flops followed by one delay flop holding the last E-high sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= {lcd_rs, lcd_rw, lcd_e, lcd_db};
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign fall = !sync2_q[8] && dly_q[8];
  assign rs   = dly_q[10];
  assign rw   = dly_q[9];
  assign db   = dly_q[7:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// Device end of an HD44780-style 8-bit bus: decodes transfers, emulates busy
// timing and keeps a 2x16 shadow of the visible DDRAM.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_SHORT = 4000,
  parameter int unsigned BUSY_LONG  = 152000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LCD_RS,
  input  logic        LCD_RW,
  input  logic        LCD_E,
  input  logic [7:0]  LCD_DB,
  input  logic [4:0]  rd_idx,
  output logic [7:0]  rd_char,
  output logic        busy,
  output logic [6:0]  ddram_addr,
  output logic        display_on,
  output logic        viol,
  output logic [15:0] xfer_cnt
);

  // Counters are loaded with N-1 so busy stays high for exactly N cycles.
  localparam logic [17:0] CntShort = 18'(BUSY_SHORT - 1);
  localparam logic [17:0] CntLong  = 18'(BUSY_LONG - 1);

  logic       fall, rs, rw;
  logic [7:0] db;

  lcd_in_sync u_in_sync (
    .clk    (clk),
    .reset  (reset),
    .lcd_rs (LCD_RS),
    .lcd_rw (LCD_RW),
    .lcd_e  (LCD_E),
    .lcd_db (LCD_DB),
    .fall   (fall),
    .rs     (rs),
    .rw     (rw),
    .db     (db)
  );

  lcd_state_e  state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic [6:0]  addr_q, addr_d;
  logic        id_q, id_d;
  logic        cg_q, cg_d;
  logic        disp_q, disp_d;
  logic        viol_q, viol_d;
  logic [15:0] xfer_q, xfer_d;

  logic [7:0]  shadow_q [32];
  logic [7:0]  rd_char_q;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_data;

  // Next-state, instruction decode and the single shadow write port.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    addr_d    = addr_q;
    id_d      = id_q;
    cg_d      = cg_q;
    disp_d    = disp_q;
    viol_d    = viol_q;
    xfer_d    = xfer_q;
    wr_en     = 1'b0;
    wr_idx    = clr_idx_q;
    wr_data   = Blank;

    unique case (state_q)
      StIdle: begin
        if (fall && !rw) begin
          xfer_d  = xfer_q + 16'd1;
          state_d = StBusy;
          cnt_d   = CntShort;
          if (rs) begin
            if (!cg_q && shadow_hit(addr_q)) begin
              wr_en   = 1'b1;
              wr_idx  = shadow_index(addr_q);
              wr_data = db;
            end
            addr_d = next_addr(addr_q, id_q);
          end else if (has_op(db, OpSetDdram)) begin
            if (addr_valid(db[6:0])) addr_d = db[6:0];
            else viol_d = 1'b1;
            cg_d = 1'b0;
          end else if (has_op(db, OpSetCgram)) begin
            cg_d = 1'b1;
          end else if (has_op(db, OpFuncSet)) begin
            // Only the 8-bit interface (DL=1) is supported.
            if (!db[4]) viol_d = 1'b1;
          end else if (has_op(db, OpShift)) begin
            if (!db[3]) addr_d = next_addr(addr_q, db[2]);
          end else if (has_op(db, OpDispCtrl)) begin
            disp_d = db[2];
          end else if (has_op(db, OpEntryMode)) begin
            id_d = db[1];
          end else if (has_op(db, OpHome)) begin
            addr_d = Line1Base;
            cnt_d  = CntLong;
          end else if (has_op(db, OpClear)) begin
            addr_d    = Line1Base;
            id_d      = 1'b1;
            cg_d      = 1'b0;
            cnt_d     = CntLong;
            clr_idx_d = 5'd0;
            state_d   = StClear;
          end
        end
      end
      StBusy: begin
        if (fall) viol_d = 1'b1;
        if (cnt_q == '0) state_d = StIdle;
        else cnt_d = cnt_q - 18'd1;
      end
      StClear: begin
        if (fall) viol_d = 1'b1;
        wr_en     = 1'b1;
        clr_idx_d = clr_idx_q + 5'd1;
        if (cnt_q != '0) cnt_d = cnt_q - 18'd1;
        if (clr_idx_q == 5'd31) state_d = (cnt_q == '0) ? StIdle : StBusy;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clr_idx_q <= '0;
      addr_q    <= Line1Base;
      id_q      <= 1'b1;
      cg_q      <= 1'b0;
      disp_q    <= 1'b0;
      viol_q    <= 1'b0;
      xfer_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      cg_q      <= cg_d;
      disp_q    <= disp_d;
      viol_q    <= viol_d;
      xfer_q    <= xfer_d;
    end
  end

  // Shadow array and registered read port; a same-cycle write is seen one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= Blank;
      rd_char_q <= Blank;
    end else begin
      if (wr_en) shadow_q[wr_idx] <= wr_data;
      rd_char_q <= shadow_q[rd_idx];
    end
  end

  assign rd_char    = rd_char_q;
  assign busy       = (state_q != StIdle);
  assign ddram_addr = addr_q;
  assign display_on = disp_q;
  assign viol       = viol_q;
  assign xfer_cnt   = xfer_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench: directed scenarios plus random bus traffic against a
// line/column reference model of the LCD.
module tb_lcd_bus_responder;

  localparam int unsigned BusyShort = 20;
  localparam int unsigned BusyLong  = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        LCD_RS, LCD_RW, LCD_E;
  logic [7:0]  LCD_DB;
  logic [4:0]  rd_idx;
  logic [7:0]  rd_char;
  logic        busy;
  logic [6:0]  ddram_addr;
  logic        display_on;
  logic        viol;
  logic [15:0] xfer_cnt;

  lcd_bus_responder #(
    .BUSY_SHORT (BusyShort),
    .BUSY_LONG  (BusyLong)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_E      (LCD_E),
    .LCD_DB     (LCD_DB),
    .rd_idx     (rd_idx),
    .rd_char    (rd_char),
    .busy       (busy),
    .ddram_addr (ddram_addr),
    .display_on (display_on),
    .viol       (viol),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Posedge index; after the Nth rising edge cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cursor kept as (line, column), display as 2x16 characters.
  int         m_line, m_col;
  logic       m_id, m_cg, m_disp, m_viol;
  int         m_xfer;
  logic [7:0] m_shadow [32];
  int         busy_until;   // first posedge index at which the device is no longer busy
  int         last_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_col = 0; m_id = 1'b1; m_cg = 1'b0; m_disp = 1'b0; m_viol = 1'b0;
    m_xfer = 0; busy_until = 0; last_k = 0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
  endtask

  task automatic model_move(input logic inc);
    if (inc) begin
      m_col++;
      if (m_col == 40) begin m_col = 0; m_line = 1 - m_line; end
    end else begin
      if (m_col == 0) begin m_col = 39; m_line = 1 - m_line; end
      else m_col--;
    end
  endtask

  // Effect of a transfer whose falling edge is acted on at posedge k.
  task automatic model_xfer(input logic rs, input logic rw, input logic [7:0] db, input int k);
    int hb;
    int a;
    bit long_busy;
    if (k - 1 < busy_until) begin
      m_viol = 1'b1;
      return;
    end
    if (rw) return;
    m_xfer = (m_xfer + 1) % 65536;
    long_busy = 0;
    if (rs) begin
      if (!m_cg && m_col < 16) m_shadow[m_line * 16 + m_col] = db;
      model_move(m_id);
    end else begin
      hb = -1;
      for (int b = 0; b < 8; b++) if (db[b]) hb = b;
      case (hb)
        7: begin
          a = int'(db) % 128;
          if (a % 64 < 40) begin m_line = a / 64; m_col = a % 64; end
          else m_viol = 1'b1;
          m_cg = 1'b0;
        end
        6: m_cg = 1'b1;
        5: if (!db[4]) m_viol = 1'b1;
        4: if (!db[3]) model_move(db[2]);
        3: m_disp = db[2];
        2: m_id = db[1];
        1: begin m_line = 0; m_col = 0; long_busy = 1; end
        0: begin
          m_line = 0; m_col = 0; m_id = 1'b1; m_cg = 1'b0; long_busy = 1;
          for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
        end
        default: ;
      endcase
    end
    busy_until = k + (long_busy ? int'(BusyLong) : int'(BusyShort));
  endtask

  task automatic check_outputs(input string tag, input logic exp_busy);
    check({tag, ".addr"}, 32'(ddram_addr), 32'(m_line * 64 + m_col));
    check({tag, ".xfer"}, 32'(xfer_cnt), 32'(m_xfer));
    check({tag, ".viol"}, 32'(viol), 32'(m_viol));
    check({tag, ".disp"}, 32'(display_on), 32'(m_disp));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  // Drive one strobe, wait for the 3rd edge after E is first seen low, then check.
  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] db,
                          input string tag);
    int k;
    LCD_RS = rs; LCD_RW = rw; LCD_DB = db; LCD_E = 1'b1;
    repeat (3) @(posedge clk);
    #1 LCD_E = 1'b0;
    repeat (3) @(posedge clk);
    #1 k = cyc;
    model_xfer(rs, rw, db, k);
    last_k = k;
    @(negedge clk);
    check_outputs(tag, k < busy_until);
  endtask

  // Must be called at the negedge right after bus_xfer; measures the busy length.
  task automatic wait_idle(input string tag);
    int n;
    int exp_n;
    n = 0;
    exp_n = (busy_until > last_k) ? busy_until - last_k : 0;
    while (busy === 1'b1 && n < int'(BusyLong) + 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, ".busylen"}, 32'(n), 32'(exp_n));
  endtask

  task automatic read_check(input int idx, input string tag);
    rd_idx = 5'(idx);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s.rd%0d", tag, idx), 32'(rd_char), 32'(m_shadow[idx]));
  endtask

  initial begin
    logic       r_rs, r_rw;
    logic [7:0] r_db;
    bit         r_wait;

    reset = 1'b1; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_E = 1'b0; LCD_DB = 8'h00; rd_idx = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("rst", 1'b0);
    check("rst.rd_char", 32'(rd_char), 32'h20);
    reset = 1'b0;

    // Set address 0, write 'A', read back with same-cycle old value first.
    bus_xfer(1'b0, 1'b0, 8'h80, "s1.cmd"); wait_idle("s1.cmd");
    rd_idx = 5'd0;
    bus_xfer(1'b1, 1'b0, 8'h41, "s1.dat");
    check("s1.rd_old", 32'(rd_char), 32'h20);
    wait_idle("s1.dat");
    read_check(0, "s1");

    // Line 2 start.
    bus_xfer(1'b0, 1'b0, 8'hC0, "s2.cmd"); wait_idle("s2.cmd");
    bus_xfer(1'b1, 1'b0, 8'h42, "s2.dat"); wait_idle("s2.dat");
    read_check(16, "s2");

    // Write while busy is dropped; read strobe in idle has no effect.
    bus_xfer(1'b1, 1'b0, 8'h43, "s5.acc");
    bus_xfer(1'b1, 1'b0, 8'h44, "s5.drop"); wait_idle("s5.drop");
    read_check(17, "s5");
    read_check(18, "s5");
    bus_xfer(1'b0, 1'b1, 8'h01, "s5.rd"); wait_idle("s5.rd");

    // Wrap rules and invalid address.
    bus_xfer(1'b0, 1'b0, 8'hA7, "s3.a27"); wait_idle("s3.a27");
    bus_xfer(1'b1, 1'b0, 8'h55, "s3.d1");  wait_idle("s3.d1");
    bus_xfer(1'b0, 1'b0, 8'h04, "s3.dec"); wait_idle("s3.dec");
    bus_xfer(1'b1, 1'b0, 8'h56, "s3.d2");  wait_idle("s3.d2");
    bus_xfer(1'b0, 1'b0, 8'hE8, "s3.bad"); wait_idle("s3.bad");
    bus_xfer(1'b0, 1'b0, 8'h0C, "s3.on");  wait_idle("s3.on");
    bus_xfer(1'b0, 1'b0, 8'h06, "s3.inc"); wait_idle("s3.inc");
    read_check(16, "s3");

    // Fill line 1, then clear.
    bus_xfer(1'b0, 1'b0, 8'h80, "s4.cmd"); wait_idle("s4.cmd");
    for (int i = 0; i < 16; i++) begin
      bus_xfer(1'b1, 1'b0, 8'(8'h30 + i), $sformatf("s4.d%0d", i));
      wait_idle("s4.d");
    end
    for (int i = 0; i < 16; i += 5) read_check(i, "s4.fill");
    bus_xfer(1'b0, 1'b0, 8'h01, "s4.clr"); wait_idle("s4.clr");
    for (int i = 0; i < 32; i++) read_check(i, "s4.clr");

    // Random traffic, sometimes without waiting for busy to drop.
    for (int it = 0; it < 80; it++) begin
      r_rs   = 1'($urandom_range(0, 1));
      r_rw   = ($urandom_range(0, 7) == 0);
      r_db   = 8'($urandom);
      r_wait = ($urandom_range(0, 4) != 0);
      bus_xfer(r_rs, r_rw, r_db, $sformatf("rnd%0d", it));
      if (r_wait) begin
        wait_idle($sformatf("rnd%0d", it));
        if ($urandom_range(0, 2) == 0) read_check(int'($urandom_range(0, 31)), "rnd");
      end
    end
    bus_xfer(1'b0, 1'b0, 8'h00, "rnd.end"); wait_idle("rnd.end");
    for (int i = 0; i < 32; i += 3) read_check(i, "rnd.final");

    // Reset in the middle of a clear.
    bus_xfer(1'b0, 1'b0, 8'h01, "s6.clr");
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("s6.rst", 1'b0);
    check("s6.rst.rd_char", 32'(rd_char), 32'h20);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_xfer(1'b0, 1'b0, 8'h80, "s6.cmd"); wait_idle("s6.cmd");
    bus_xfer(1'b1, 1'b0, 8'h41, "s6.dat"); wait_idle("s6.dat");
    read_check(0, "s6");
    read_check(1, "s6");
    read_check(20, "s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
